// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types and constants for the video post-processing path
package video_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic SYNC_IDLE  = 1'b1;
    localparam logic BLANK_IDLE = 1'b0;

    localparam int DEF_LINE_WIDTH   = 640;
    localparam int DEF_FRAME_HEIGHT = 480;
    localparam int DEF_PIXEL_DEPTH  = 8;

endpackage

// File: rtl/conv_border_mask_if.sv
// rtl/conv_border_mask_if.sv - video stream bundle: active-low syncs, blank and RGB pixel
interface conv_border_mask_if
    import video_pkg::*;
#(
    parameter int PIXEL_DEPTH = DEF_PIXEL_DEPTH
);
    logic                   vs_n;
    logic                   hs_n;
    logic                   blank_n;
    logic [PIXEL_DEPTH-1:0] red;
    logic [PIXEL_DEPTH-1:0] green;
    logic [PIXEL_DEPTH-1:0] blue;

    modport master (
        output vs_n, hs_n, blank_n, red, green, blue
    );

    modport slave (
        input vs_n, hs_n, blank_n, red, green, blue
    );
endinterface

// File: rtl/video_pos_counter.sv
// rtl/video_pos_counter.sv - pixel column/row tracking from vs and blank edges
module video_pos_counter
    import video_pkg::*;
#(
    parameter  int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter  int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    localparam int CW           = $clog2(LINE_WIDTH + 1),
    localparam int RW           = $clog2(FRAME_HEIGHT + 1)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          vs_ni,
    input  logic          blank_ni,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          line_end_o,
    output logic          frame_start_o,
    output logic          len_err_o
);

    localparam logic [CW-1:0] COL_MAX = CW'(LINE_WIDTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(FRAME_HEIGHT);

    logic          vs_q;
    logic          blank_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    assign line_end_o    = blank_q & ~blank_ni;
    assign frame_start_o = vs_q & ~vs_ni;
    // col_q still holds the visible-pixel count of the line that just ended
    assign len_err_o     = line_end_o & (col_q != COL_MAX);

    always_comb begin
        col_d = '0;
        if (blank_ni) begin
            col_d = (col_q == COL_MAX) ? col_q : col_q + 1'b1;
        end
        row_d = row_q;
        if (frame_start_o) begin
            row_d = '0;
        end else if (line_end_o && (row_q != ROW_MAX)) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_q    <= SYNC_IDLE;
            blank_q <= BLANK_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else if (en_i) begin
            vs_q    <= vs_ni;
            blank_q <= blank_ni;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/conv_border_mask.sv
// rtl/conv_border_mask.sv - masks frame-edge pixels after the 3x3 convolution and monitors frame lock
module conv_border_mask
    import video_pkg::*;
#(
    parameter  int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter  int FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter  int PIXEL_DEPTH  = DEF_PIXEL_DEPTH,
    parameter  int BORDER       = 1,
    parameter  int BORDER_COLOR = 0,
    localparam int CW           = $clog2(LINE_WIDTH + 1),
    localparam int RW           = $clog2(FRAME_HEIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               en_i,
    conv_border_mask_if.slave  vid_i,
    conv_border_mask_if.master vid_o,
    output logic               frame_locked_o,
    output logic               line_err_o
);

    localparam logic [PIXEL_DEPTH-1:0] MASK_PIX = PIXEL_DEPTH'(BORDER_COLOR);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          line_end;
    logic          frame_start;
    logic          len_err;

    state_t state_q, state_d;
    logic   line_err_q, line_err_d;
    logic   in_edge;

    logic                   vs_out_q, hs_out_q, blank_out_q;
    logic [PIXEL_DEPTH-1:0] r_q, g_q, b_q;
    logic [PIXEL_DEPTH-1:0] r_d, g_d, b_d;

    video_pos_counter #(
        .LINE_WIDTH  (LINE_WIDTH),
        .FRAME_HEIGHT(FRAME_HEIGHT)
    ) u_pos (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .vs_ni        (vid_i.vs_n),
        .blank_ni     (vid_i.blank_n),
        .col_o        (col),
        .row_o        (row),
        .line_end_o   (line_end),
        .frame_start_o(frame_start),
        .len_err_o    (len_err)
    );

    // A length violation outranks a coincident frame start while locked
    always_comb begin
        state_d    = state_q;
        line_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (frame_start) state_d = LOCKED;
            end
            LOCKED: begin
                if (line_end && len_err) begin
                    state_d    = SEARCH;
                    line_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        in_edge = (BORDER > 0) &&
                  ((int'(col) < BORDER) || (int'(col) >= LINE_WIDTH - BORDER) ||
                   (int'(row) < BORDER) || (int'(row) >= FRAME_HEIGHT - BORDER));
        r_d = vid_i.red;
        g_d = vid_i.green;
        b_d = vid_i.blue;
        if (!vid_i.blank_n) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end else if ((state_q == SEARCH) || in_edge) begin
            r_d = MASK_PIX;
            g_d = MASK_PIX;
            b_d = MASK_PIX;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            line_err_q  <= 1'b0;
            vs_out_q    <= SYNC_IDLE;
            hs_out_q    <= SYNC_IDLE;
            blank_out_q <= BLANK_IDLE;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else if (en_i) begin
            state_q     <= state_d;
            line_err_q  <= line_err_d;
            vs_out_q    <= vid_i.vs_n;
            hs_out_q    <= vid_i.hs_n;
            blank_out_q <= vid_i.blank_n;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign vid_o.vs_n      = vs_out_q;
    assign vid_o.hs_n      = hs_out_q;
    assign vid_o.blank_n   = blank_out_q;
    assign vid_o.red       = r_q;
    assign vid_o.green     = g_q;
    assign vid_o.blue      = b_q;
    assign frame_locked_o  = (state_q == LOCKED);
    assign line_err_o      = line_err_q;

endmodule

// File: tb/tb_conv_border_mask.sv
// tb/tb_conv_border_mask.sv - directed bench for conv_border_mask on a reduced 16x8 frame
module tb_conv_border_mask;
    import video_pkg::*;

    localparam int          LW  = 16;
    localparam int          FH  = 8;
    localparam int          B   = 1;
    localparam logic [7:0]  BC2 = 8'h5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;
    logic lk1, le1, lk2, le2;

    conv_border_mask_if #(.PIXEL_DEPTH(8)) vin ();
    conv_border_mask_if #(.PIXEL_DEPTH(8)) vo1 ();
    conv_border_mask_if #(.PIXEL_DEPTH(8)) vo2 ();

    conv_border_mask #(
        .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PIXEL_DEPTH(8), .BORDER(B), .BORDER_COLOR(0)
    ) dut1 (
        .clk(clk), .rst_ni(rst_n), .en_i(en), .vid_i(vin), .vid_o(vo1),
        .frame_locked_o(lk1), .line_err_o(le1)
    );

    conv_border_mask #(
        .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PIXEL_DEPTH(8), .BORDER(0), .BORDER_COLOR(int'(BC2))
    ) dut2 (
        .clk(clk), .rst_ni(rst_n), .en_i(en), .vid_i(vin), .vid_o(vo2),
        .frame_locked_o(lk2), .line_err_o(le2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit lk        = 1'b0;
    bit toggle_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int row, input int col);
        return {8'h80, 8'(8'h10 + col), 8'(8'h40 + row)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input logic vs, input logic hs, input logic bl,
                              input logic [23:0] e1, input logic [23:0] e2,
                              input bit elk, input bit ee);
        check_val("sync", 32'({vo1.vs_n, vo1.hs_n, vo1.blank_n, vo2.vs_n, vo2.hs_n, vo2.blank_n}),
                  32'({vs, hs, bl, vs, hs, bl}));
        check_val("rgb_b1", 32'({vo1.red, vo1.green, vo1.blue}), 32'(e1));
        check_val("rgb_b0", 32'({vo2.red, vo2.green, vo2.blue}), 32'(e2));
        check_val("locked", 32'({lk1, lk2}), 32'({elk, elk}));
        check_val("line_err", 32'({le1, le2}), 32'({ee, ee}));
    endtask

    // lk must already hold the lock state expected after this edge
    task automatic cyc(input logic vs, input logic hs, input logic bl,
                       input int row, input int col, input bit ee);
        logic [23:0] p, e1, e2;
        bit          on_edge;
        p = bl ? pix(row, col) : 24'hEEEEEE;
        vin.vs_n = vs;
        vin.hs_n = hs;
        vin.blank_n = bl;
        {vin.red, vin.green, vin.blue} = p;
        en = 1'b1;
        on_edge = (col < B) || (col >= LW - B) || (row < B) || (row >= FH - B);
        e1 = !bl ? 24'h0 : ((!lk || on_edge) ? 24'h0 : p);
        e2 = !bl ? 24'h0 : (!lk ? {3{BC2}} : p);
        tick();
        check_outs(vs, hs, bl, e1, e2, lk, ee);
        if (toggle_en) begin
            en = 1'b0;
            vin.vs_n = 1'b0;
            vin.hs_n = 1'b0;
            vin.blank_n = 1'b1;
            {vin.red, vin.green, vin.blue} = 24'($urandom);
            tick();
            check_outs(vs, hs, bl, e1, e2, lk, ee);
            en = 1'b1;
        end
    endtask

    task automatic vsync;
        lk = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic line(input int row, input int c0, input int npix, input logic vs_end);
        bit ee;
        for (int c = c0; c < npix; c++) cyc(1'b1, 1'b1, 1'b1, row, c, 1'b0);
        ee = 1'b0;
        if (lk) begin
            if ((npix - c0) != LW) begin
                ee = 1'b1;
                lk = 1'b0;
            end
        end else if (!vs_end) begin
            lk = 1'b1;
        end
        cyc(vs_end, 1'b1, 1'b0, row, 0, ee);
        cyc(vs_end, 1'b0, 1'b0, row, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, row, 0, 1'b0);
    endtask

    task automatic frame(input int short_row);
        vsync();
        for (int r = 0; r < FH; r++) line(r, 0, (r == short_row) ? LW - 1 : LW, 1'b1);
    endtask

    initial begin
        vin.vs_n = 1'b1;
        vin.hs_n = 1'b1;
        vin.blank_n = 1'b0;
        {vin.red, vin.green, vin.blue} = 24'h0;
        #1 rst_n = 1'b0;
        #2;
        check_outs(1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        check_val("reset_state", 32'(dut1.state_q), 32'(SEARCH));
        tick();
        tick();
        rst_n = 1'b1;

        // no vs edge yet: everything masked, short line raises no pulse
        line(0, 0, LW, 1'b1);
        line(1, 0, LW - 1, 1'b1);
        line(2, 0, LW, 1'b1);

        frame(-1);
        frame(3);
        frame(-1);

        toggle_en = 1'b1;
        frame(-1);
        toggle_en = 1'b0;

        // frame start coinciding with a good line end, then with a short one
        vsync();
        for (int r = 0; r < 5; r++) line(r, 0, LW, (r == 4) ? 1'b0 : 1'b1);
        check_val("row_clr_ok", 32'(dut1.u_pos.row_q), 32'd0);
        for (int r = 0; r < FH; r++)
            line(r, 0, (r == FH - 1) ? LW - 1 : LW, (r == FH - 1) ? 1'b0 : 1'b1);
        check_val("row_clr_err", 32'(dut1.u_pos.row_q), 32'd0);
        frame(-1);

        // asynchronous reset in the middle of row 2
        vsync();
        line(0, 0, LW, 1'b1);
        line(1, 0, LW, 1'b1);
        for (int c = 0; c < 5; c++) cyc(1'b1, 1'b1, 1'b1, 2, c, 1'b0);
        rst_n = 1'b0;
        #2;
        check_outs(1'b1, 1'b1, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        check_val("midreset_state", 32'(dut1.state_q), 32'(SEARCH));
        lk = 1'b0;
        tick();
        rst_n = 1'b1;
        line(2, 5, LW, 1'b1);
        for (int r = 3; r < FH; r++) line(r, 0, LW, 1'b1);
        frame(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
